// File: rtl/four_input_debounce_pkg.sv
// Shared constants for the four-input debounce stage: channel count, default
// tuning and the bit position of each gate input within raw/chg.
package four_input_pkg;
    localparam int NUM_CH          = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;
    localparam int CH_A            = 3;
    localparam int CH_B            = 2;
    localparam int CH_C            = 1;
    localparam int CH_D            = 0;
endpackage

// File: rtl/four_input_debounce_chan.sv
// One debounce channel: a synchroniser chain feeding a saturating stability
// counter that flips the clean output after DB_CYCLES consecutive mismatches.
module debounce_chan
    import four_input_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic out,
    output logic chg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_x;

    assign sync_x = sync_q[SYNC_STAGES-1];

    // The chain keeps shifting even while en is low so that re-enabling
    // never acts on a stale sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
            chg <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            chg <= 1'b0;
        end else if (sync_x == out) begin
            cnt <= '0;
            chg <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            out <= ~out;
            chg <= 1'b1;
        end else begin
            cnt <= cnt + CNT_W'(1);
            chg <= 1'b0;
        end
    end

endmodule

// File: rtl/four_input_debounce.sv
// Conditions the four raw inputs of the downstream AND gate: one independent
// debounce channel per input, outputs mapped onto a/b/c/d.
module four_input_debounce
    import four_input_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_CH-1:0]   raw,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                d,
    output logic [NUM_CH-1:0]   chg
);

    logic [NUM_CH-1:0] out_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .raw   (raw[i]),
            .out   (out_v[i]),
            .chg   (chg[i])
        );
    end

    assign a = out_v[CH_A];
    assign b = out_v[CH_B];
    assign c = out_v[CH_C];
    assign d = out_v[CH_D];

endmodule

// File: tb/tb_four_input_debounce.sv
// Directed bench for four_input_debounce: a default build (2 sync, 4 cycles)
// and a DB_CYCLES=1 build share clock and reset.
module tb_four_input_debounce;

    logic       clk;
    logic       rst_n;
    logic       en0, en1;
    logic [3:0] raw0, raw1;
    logic       a0, b0, c0, d0;
    logic       a1, b1, c1, d1;
    logic [3:0] chg0, chg1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    four_input_debounce dut (
        .clk (clk), .rst_n (rst_n), .en (en0), .raw (raw0),
        .a (a0), .b (b0), .c (c0), .d (d0), .chg (chg0)
    );

    four_input_debounce #(.DB_CYCLES(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .en (en1), .raw (raw1),
        .a (a1), .b (b1), .c (c1), .d (d1), .chg (chg1)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected entry: {outputs abcd, chg} of the default build, then of the DB=1 build.
    task automatic push(input string tag, input logic [3:0] o0, input logic [3:0] g0,
                        input logic [3:0] o1, input logic [3:0] g1, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({o0, g0, o1, g1});
            tag_q.push_back(tag);
        end
    endtask

    task automatic check_now();
        logic [15:0] obs;
        logic [15:0] exp;
        string       tag;
        obs = {a0, b0, c0, d0, chg0, a1, b1, c1, d1, chg1};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%h required=%h", tag, obs, exp);
            end
        end
    endtask

    // Advance n rising edges, comparing at the falling edge after each.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_now();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en0   = 1'b1;
        en1   = 1'b1;
        raw0  = 4'b1111;
        raw1  = 4'b0000;

        // reset with all raw inputs high
        #1;
        push("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 1);
        check_now();
        push("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 3);
        run(3);
        rst_n = 1'b1;
        push("reset_release_wait", 4'h0, 4'h0, 4'h0, 4'h0, 5);
        push("reset_release_rise", 4'hF, 4'hF, 4'h0, 4'h0, 1);
        push("reset_release_hold", 4'hF, 4'h0, 4'h0, 4'h0, 1);
        run(7);

        // all channels fall together
        raw0 = 4'b0000;
        push("all_fall_wait", 4'hF, 4'h0, 4'h0, 4'h0, 5);
        push("all_fall_edge", 4'h0, 4'hF, 4'h0, 4'h0, 1);
        push("all_fall_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1);
        run(7);

        // single clean transition on a
        raw0 = 4'b1000;
        push("clean_a_wait", 4'h0, 4'h0, 4'h0, 4'h0, 5);
        push("clean_a_edge", 4'h8, 4'h8, 4'h0, 4'h0, 1);
        push("clean_a_hold", 4'h8, 4'h0, 4'h0, 4'h0, 2);
        run(8);

        // bounce on b: 3 high, 1 low, 2 high, then low
        raw0 = 4'b1100;
        push("bounce_b", 4'h8, 4'h0, 4'h0, 4'h0, 3);
        run(3);
        raw0 = 4'b1000;
        push("bounce_b", 4'h8, 4'h0, 4'h0, 4'h0, 1);
        run(1);
        raw0 = 4'b1100;
        push("bounce_b", 4'h8, 4'h0, 4'h0, 4'h0, 2);
        run(2);
        raw0 = 4'b1000;
        push("bounce_b", 4'h8, 4'h0, 4'h0, 4'h0, 6);
        run(6);

        // bring a back low
        raw0 = 4'b0000;
        push("a_fall_wait", 4'h8, 4'h0, 4'h0, 4'h0, 5);
        push("a_fall_edge", 4'h0, 4'h8, 4'h0, 4'h0, 1);
        push("a_fall_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1);
        run(7);

        // en gating: change held while disabled, full count after en rises
        en0  = 1'b0;
        raw0 = 4'b0101;
        push("en_low_frozen", 4'h0, 4'h0, 4'h0, 4'h0, 10);
        run(10);
        en0 = 1'b1;
        push("en_rise_wait", 4'h0, 4'h0, 4'h0, 4'h0, 3);
        push("en_rise_edge", 4'h5, 4'h5, 4'h0, 4'h0, 1);
        push("en_rise_hold", 4'h5, 4'h0, 4'h0, 4'h0, 1);
        run(5);

        // reset mid-count on c while b and d are high
        raw0 = 4'b0111;
        push("midcount_pre", 4'h5, 4'h0, 4'h0, 4'h0, 4);
        run(4);
        rst_n = 1'b0;
        #1;
        push("midcount_async_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1);
        check_now();
        push("midcount_reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 2);
        run(2);
        rst_n = 1'b1;
        push("post_reset_wait", 4'h0, 4'h0, 4'h0, 4'h0, 5);
        push("post_reset_edge", 4'h7, 4'h7, 4'h0, 4'h0, 1);
        push("post_reset_hold", 4'h7, 4'h0, 4'h0, 4'h0, 1);
        run(7);

        // DB_CYCLES=1 build: c input toggles every 3 cycles, lag of 3 edges
        for (int k = 1; k <= 15; k++) begin
            int          toggles;
            logic [3:0]  o1;
            logic [3:0]  g1;
            if (k <= 12) raw1 = (((k - 1) / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            else         raw1 = 4'b0000;
            toggles = int'(k >= 3) + int'(k >= 6) + int'(k >= 9) + int'(k >= 12);
            o1 = (toggles % 2 == 1) ? 4'b0010 : 4'b0000;
            g1 = (k == 3 || k == 6 || k == 9 || k == 12) ? 4'b0010 : 4'b0000;
            push("db1_toggle", 4'h7, 4'h0, o1, g1, 1);
            run(1);
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_input_debounce.md
Name: four_input_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the four-input AND gate.
- Takes four raw, asynchronous, possibly bouncing inputs and synchronises each one into the clock domain.
- Debounces each channel independently, then drives clean, stable levels a, b, c, d into the gate's a/b/c/d inputs.
- Also emits a one-cycle change strobe per channel for downstream logging and monitors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each synchroniser chain; legal range 2..4.
- DB_CYCLES, 4, consecutive cycles the synchronised input must differ from the current output before the output flips; legal range 1..255.
- CNT_W, 8, width of the per-channel stability counter; must satisfy 2**CNT_W > DB_CYCLES.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  debounce enable; when low, outputs freeze.
- raw  input  4  raw inputs; raw[3]=a, raw[2]=b, raw[1]=c, raw[0]=d; asynchronous to clk.
- a  output  1  debounced channel a.
- b  output  1  debounced channel b.
- c  output  1  debounced channel c.
- d  output  1  debounced channel d.
- chg  output  4  per-channel change strobe, same bit order as raw.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on assertion regardless of clk:
  - all synchroniser flops 0;
  - all counters 0;
  - a, b, c, d = 0;
  - chg = 4'b0000.
- Reset release: deassertion is taken at a clk edge; no output may change on the release edge itself.
- Synchroniser: per channel, a shift chain of SYNC_STAGES flops. The last stage is sync_x. sync_x is the only value the debounce logic sees; raw is never used combinationally.
- Per-channel debounce, evaluated at every clk rising edge when en=1:
  - sync_x == out_x: counter cleared to 0; out_x holds.
  - sync_x != out_x and counter < DB_CYCLES-1: counter increments by 1; out_x holds.
  - sync_x != out_x and counter == DB_CYCLES-1: out_x inverts; counter cleared to 0; chg_x=1 for exactly the following cycle.
- Latency: raw_x changes between edges and stays stable. The first edge after the change is edge 1. out_x changes on edge SYNC_STAGES+DB_CYCLES. With defaults this is edge 6.
- Glitch rejection: a mismatch lasting fewer than DB_CYCLES consecutive evaluated cycles clears the counter and produces no output change and no chg pulse.
- chg: registered. Bit x is high for one cycle after each out_x toggle and 0 in every other cycle. Channels toggling on the same edge assert their bits simultaneously.
- en=0:
  - synchronisers keep shifting;
  - counters are held at 0;
  - a, b, c, d hold their values;
  - chg = 0.
  - When en rises, counting restarts from 0, so a pending change needs a full DB_CYCLES again.
- DB_CYCLES=1: out_x follows sync_x with one cycle of delay; chg pulses on every change.
- Counter never wraps: it is bounded by DB_CYCLES-1.
- Reset mid-count: all in-flight counts and synchroniser contents are discarded; outputs return to 0.
- Channels are fully independent: no cross-channel interaction.

Decomposition:
- Shared package four_input_pkg:
  - NUM_CH = 4;
  - default constants SYNC_STAGES_DEF = 2, DB_CYCLES_DEF = 4;
  - channel index constants CH_A=3, CH_B=2, CH_C=1, CH_D=0.
- Sub-module debounce_chan, instantiated four times.
  - Contains one synchroniser chain, one counter, out_x and chg_x.
  - Top level only splits raw, maps outputs to a/b/c/d, and distributes parameters.

Test Plan:
- Reset: rst_n=0 with raw=4'b1111, hold 3 cycles, then release -> a,b,c,d=0 and chg=0 during reset. All four outputs rise together on edge 6 after release; chg=4'b1111 for one cycle.
- Single clean transition: en=1, raw goes 0000 -> 1000 and holds -> a=1 on edge 6; chg=4'b1000 for exactly one cycle; b,c,d stay 0.
- Bounce rejection: raw[2] pulses high for 3 cycles, low for 1, high for 2, then low -> b stays 0 throughout; chg stays 0.
- en gating: en=0, raw 0000 -> 0101, held 10 cycles -> outputs unchanged. Raise en -> c,d... correction: d and b (raw[2], raw[0]) go to 1 exactly 4 edges after en rises; chg=4'b0101 once.
- Reset mid-count: raw[0] rises; assert rst_n low at edge 4 -> d never goes high before reset; all state is 0 after reset. After release with raw[0] still high, d=1 at edge 6.
- DB_CYCLES=1 build: raw[1] toggles every 3 cycles -> c toggles every 3 cycles with a lag of 3 edges (2 sync + 1); a chg[1] pulse accompanies every toggle.
